// File: rtl/fc_backward_if.sv
// fc_backward_if: bundles the request, operand and result signals of the
// fully-connected backward-pass engine.
//   start       : request one backward pass (sampled while idle)
//   data        : forward-pass activations   [batch_size][feature_size] x 32
//   weight      : forward-pass weights       [feature_size][bias_size]  x 32
//   grad_out    : loss gradient at the output [batch_size][bias_size]   x 32
//   grad_data   : grad_out x weight^T         [batch_size][feature_size] x 32
//   grad_weight : data^T x grad_out           [feature_size][bias_size]  x 32
//   grad_bias   : column sums of grad_out     [bias_size] x 32
//   busy        : high while a pass is in progress
//   done        : one-cycle completion pulse
// The master modport is the requester; the slave modport is the engine.
interface fc_backward_if #(
    parameter int batch_size   = 1,
    parameter int feature_size = 3,
    parameter int bias_size    = 2
) ();
    logic                                          start;
    logic [batch_size-1:0][feature_size-1:0][31:0] data;
    logic [feature_size-1:0][bias_size-1:0][31:0]  weight;
    logic [batch_size-1:0][bias_size-1:0][31:0]    grad_out;
    logic [batch_size-1:0][feature_size-1:0][31:0] grad_data;
    logic [feature_size-1:0][bias_size-1:0][31:0]  grad_weight;
    logic [bias_size-1:0][31:0]                    grad_bias;
    logic                                          busy;
    logic                                          done;

    modport master (
        output start, data, weight, grad_out,
        input  grad_data, grad_weight, grad_bias, busy, done
    );

    modport slave (
        input  start, data, weight, grad_out,
        output grad_data, grad_weight, grad_bias, busy, done
    );
endinterface

// File: rtl/fc_backward.sv
// fc_backward: backward pass of a fully-connected layer using one shared
// 32-bit multiply-accumulate unit, one product term per cycle.
//   Phases: GB (grad_bias), GW (grad_weight), GX (grad_data), then a single
//   DONE cycle with done=1/busy=0 before returning to IDLE.
//   Each output element is reduced over its innermost index and written on
//   its last term; elements are visited row-major.
// Ports:
//   clk : single clock, all state on the rising edge
//   rst : asynchronous, active-high reset
//   bus : fc_backward_if.slave (start, operands in; gradients, busy, done out)
// Configuration macro:
//   FC_BACKWARD_GRAD_DATA_EN : when defined, the GX phase is built and
//   grad_data is computed; otherwise GW goes straight to DONE and grad_data
//   is tied to zero.
// Arithmetic is two's complement, low 32 bits kept, wrap-around.
module fc_backward #(
    parameter int batch_size   = 1,
    parameter int feature_size = 3,
    parameter int bias_size    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fc_backward_if.slave bus
);

    typedef logic [batch_size-1:0][feature_size-1:0][31:0] mat_bf_t;
    typedef logic [feature_size-1:0][bias_size-1:0][31:0]  mat_fn_t;
    typedef logic [batch_size-1:0][bias_size-1:0][31:0]    mat_bn_t;
    typedef logic [bias_size-1:0][31:0]                    vec_n_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GB   = 3'd1,
        GW   = 3'd2,
`ifdef FC_BACKWARD_GRAD_DATA_EN
        GX   = 3'd3,
`endif
        DONE = 3'd4
    } state_t;

    localparam logic [31:0] B_LAST = 32'(batch_size - 1);
    localparam logic [31:0] F_LAST = 32'(feature_size - 1);
    localparam logic [31:0] N_LAST = 32'(bias_size - 1);

    state_t        state_q, state_d;
    logic [31:0]   e0_q, e0_d;      // outer output-element index
    logic [31:0]   e1_q, e1_d;      // inner output-element index
    logic [31:0]   r_q, r_d;        // reduction index (innermost)
    logic [31:0]   acc_q, acc_d;
    mat_bf_t       data_q, data_d;
    mat_bn_t       gout_q, gout_d;
    vec_n_t        gbias_q, gbias_d;
    mat_fn_t       gweight_q, gweight_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
`ifdef FC_BACKWARD_GRAD_DATA_EN
    mat_fn_t       weight_q, weight_d;
    mat_bf_t       gdata_q, gdata_d;
`else
    logic          unused_weight_s;
`endif

    logic [31:0]   a_s, b_s, prod_s, sum_s;
    logic [31:0]   e0_max_s, e1_max_s, r_max_s;
    logic          r_last_s, e1_last_s, e0_last_s, phase_last_s;
    logic          mac_active_s;

    // Operand selection and loop bounds for the phase in progress.
    always_comb begin
        a_s      = 32'd0;
        b_s      = 32'd0;
        e0_max_s = 32'd0;
        e1_max_s = 32'd0;
        r_max_s  = 32'd0;
        case (state_q)
            GB: begin
                // grad_bias[j] = sum_i grad_out[i][j]; multiplier fixed at 1
                e0_max_s = N_LAST;
                r_max_s  = B_LAST;
                b_s      = 32'd1;
                for (int i = 0; i < batch_size; i++) begin
                    for (int j = 0; j < bias_size; j++) begin
                        a_s = ((32'(i) == r_q) && (32'(j) == e0_q)) ? gout_q[i][j] : a_s;
                    end
                end
            end
            GW: begin
                // grad_weight[f][j] = sum_i data[i][f] * grad_out[i][j]
                e0_max_s = F_LAST;
                e1_max_s = N_LAST;
                r_max_s  = B_LAST;
                for (int i = 0; i < batch_size; i++) begin
                    for (int f = 0; f < feature_size; f++) begin
                        a_s = ((32'(i) == r_q) && (32'(f) == e0_q)) ? data_q[i][f] : a_s;
                    end
                    for (int j = 0; j < bias_size; j++) begin
                        b_s = ((32'(i) == r_q) && (32'(j) == e1_q)) ? gout_q[i][j] : b_s;
                    end
                end
            end
`ifdef FC_BACKWARD_GRAD_DATA_EN
            GX: begin
                // grad_data[i][f] = sum_j grad_out[i][j] * weight[f][j]
                e0_max_s = B_LAST;
                e1_max_s = F_LAST;
                r_max_s  = N_LAST;
                for (int j = 0; j < bias_size; j++) begin
                    for (int i = 0; i < batch_size; i++) begin
                        a_s = ((32'(i) == e0_q) && (32'(j) == r_q)) ? gout_q[i][j] : a_s;
                    end
                    for (int f = 0; f < feature_size; f++) begin
                        b_s = ((32'(f) == e1_q) && (32'(j) == r_q)) ? weight_q[f][j] : b_s;
                    end
                end
            end
`endif
            default: begin
                a_s = 32'd0;
                b_s = 32'd0;
            end
        endcase
    end

    // Shared MAC datapath and term/element/phase end detection.
    always_comb begin
        prod_s       = a_s * b_s;
        sum_s        = acc_q + prod_s;
        r_last_s     = (r_q == r_max_s);
        e1_last_s    = (e1_q == e1_max_s);
        e0_last_s    = (e0_q == e0_max_s);
        phase_last_s = r_last_s && e1_last_s && e0_last_s;
        case (state_q)
            GB, GW:  mac_active_s = 1'b1;
`ifdef FC_BACKWARD_GRAD_DATA_EN
            GX:      mac_active_s = 1'b1;
`endif
            default: mac_active_s = 1'b0;
        endcase
    end

    // Next-state, operand capture, counter stepping and result write-back.
    always_comb begin
        state_d   = state_q;
        e0_d      = e0_q;
        e1_d      = e1_q;
        r_d       = r_q;
        acc_d     = acc_q;
        data_d    = data_q;
        gout_d    = gout_q;
        gbias_d   = gbias_q;
        gweight_d = gweight_q;
`ifdef FC_BACKWARD_GRAD_DATA_EN
        weight_d  = weight_q;
        gdata_d   = gdata_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Operands are snapshotted so later port changes cannot disturb the pass.
                    state_d   = GB;
                    data_d    = bus.data;
                    gout_d    = bus.grad_out;
                    gbias_d   = '0;
                    gweight_d = '0;
                    e0_d      = 32'd0;
                    e1_d      = 32'd0;
                    r_d       = 32'd0;
                    acc_d     = 32'd0;
`ifdef FC_BACKWARD_GRAD_DATA_EN
                    weight_d  = bus.weight;
                    gdata_d   = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GB: begin
                for (int j = 0; j < bias_size; j++) begin
                    gbias_d[j] = (r_last_s && (32'(j) == e0_q)) ? sum_s : gbias_d[j];
                end
                state_d = phase_last_s ? GW : GB;
            end
            GW: begin
                for (int f = 0; f < feature_size; f++) begin
                    for (int j = 0; j < bias_size; j++) begin
                        gweight_d[f][j] = (r_last_s && (32'(f) == e0_q) && (32'(j) == e1_q))
                                          ? sum_s : gweight_d[f][j];
                    end
                end
`ifdef FC_BACKWARD_GRAD_DATA_EN
                state_d = phase_last_s ? GX : GW;
`else
                state_d = phase_last_s ? DONE : GW;
`endif
            end
`ifdef FC_BACKWARD_GRAD_DATA_EN
            GX: begin
                for (int i = 0; i < batch_size; i++) begin
                    for (int f = 0; f < feature_size; f++) begin
                        gdata_d[i][f] = (r_last_s && (32'(i) == e0_q) && (32'(f) == e1_q))
                                        ? sum_s : gdata_d[i][f];
                    end
                end
                state_d = phase_last_s ? DONE : GX;
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Counters wrap to zero at phase end, so the next phase starts clean.
        if (mac_active_s) begin
            acc_d = r_last_s ? 32'd0 : sum_s;
            r_d   = r_last_s ? 32'd0 : (r_q + 32'd1);
            if (r_last_s) begin
                e1_d = e1_last_s ? 32'd0 : (e1_q + 32'd1);
                e0_d = e1_last_s ? (e0_last_s ? 32'd0 : (e0_q + 32'd1)) : e0_q;
            end else begin
                e1_d = e1_q;
                e0_d = e0_q;
            end
        end else begin
            acc_d = acc_d;
        end

        case (state_d)
            GB, GW:  busy_d = 1'b1;
`ifdef FC_BACKWARD_GRAD_DATA_EN
            GX:      busy_d = 1'b1;
`endif
            default: busy_d = 1'b0;
        endcase
        done_d = (state_d == DONE);
    end

    // State and datapath registers; reset clears everything including mid-pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            e0_q      <= 32'd0;
            e1_q      <= 32'd0;
            r_q       <= 32'd0;
            acc_q     <= 32'd0;
            data_q    <= '0;
            gout_q    <= '0;
            gbias_q   <= '0;
            gweight_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef FC_BACKWARD_GRAD_DATA_EN
            weight_q  <= '0;
            gdata_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            e0_q      <= e0_d;
            e1_q      <= e1_d;
            r_q       <= r_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            gout_q    <= gout_d;
            gbias_q   <= gbias_d;
            gweight_q <= gweight_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef FC_BACKWARD_GRAD_DATA_EN
            weight_q  <= weight_d;
            gdata_q   <= gdata_d;
`endif
        end
    end

    assign bus.grad_bias   = gbias_q;
    assign bus.grad_weight = gweight_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
`ifdef FC_BACKWARD_GRAD_DATA_EN
    assign bus.grad_data   = gdata_q;
`else
    assign bus.grad_data       = '0;
    assign unused_weight_s = ^bus.weight;
`endif

endmodule

// File: tb/tb_fc_backward.sv
module tb_fc_backward;

    localparam int B = 1;
    localparam int F = 3;
    localparam int N = 2;
`ifdef FC_BACKWARD_GRAD_DATA_EN
    localparam bit GX_ON = 1'b1;
`else
    localparam bit GX_ON = 1'b0;
`endif
    localparam int TERMS = B*N + F*N*B + (GX_ON ? B*F*N : 0);

    typedef logic [B-1:0][F-1:0][31:0] bf_t;
    typedef logic [F-1:0][N-1:0][31:0] fn_t;
    typedef logic [B-1:0][N-1:0][31:0] bn_t;
    typedef logic [N-1:0][31:0]        n_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fc_backward_if #(.batch_size(B), .feature_size(F), .bias_size(N)) bus0 ();
    fc_backward_if #(.batch_size(2), .feature_size(3), .bias_size(2)) bus1 ();

    fc_backward #(.batch_size(B), .feature_size(F), .bias_size(N)) u0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    fc_backward #(.batch_size(2), .feature_size(3), .bias_size(2)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model (matrix algebra) ----------------
    function automatic n_t f_gb(input bn_t g);
        n_t r = '0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < B; i++)
                r[j] += g[i][j];
        return r;
    endfunction

    function automatic fn_t f_gw(input bf_t d, input bn_t g);
        fn_t r = '0;
        for (int f = 0; f < F; f++)
            for (int j = 0; j < N; j++)
                for (int i = 0; i < B; i++)
                    r[f][j] += d[i][f] * g[i][j];
        return r;
    endfunction

    function automatic bf_t f_gd(input bn_t g, input fn_t w);
        bf_t r = '0;
        for (int i = 0; i < B; i++)
            for (int f = 0; f < F; f++)
                for (int j = 0; j < N; j++)
                    r[i][f] += g[i][j] * w[f][j];
        return r;
    endfunction

    int  m_left;
    bit  m_done;
    bf_t m_d;
    fn_t m_w;
    bn_t m_g;
    n_t  x_gb;
    fn_t x_gw;
    bf_t x_gd;

    // model: a pass is busy for TERMS cycles, then one done cycle
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_d    <= '0;
            m_w    <= '0;
            m_g    <= '0;
            x_gb   <= '0;
            x_gw   <= '0;
            x_gd   <= '0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                x_gb   <= f_gb(m_g);
                x_gw   <= f_gw(m_d, m_g);
                x_gd   <= GX_ON ? f_gd(m_g, m_w) : '0;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (bus0.start === 1'b1) begin
            m_d    <= bus0.data;
            m_w    <= bus0.weight;
            m_g    <= bus0.grad_out;
            m_left <= TERMS;
            x_gb   <= '0;
            x_gw   <= '0;
            x_gd   <= '0;
        end
    end

    // compare process: status every cycle, gradients whenever not busy
    always @(negedge clk) begin
        if (!rst) begin
            chk("busy", 32'(bus0.busy), 32'(m_left != 0));
            chk("done", 32'(bus0.done), 32'(m_done));
            if (m_left == 0) begin
                for (int j = 0; j < N; j++)
                    chk($sformatf("grad_bias[%0d]", j), bus0.grad_bias[j], x_gb[j]);
                for (int f = 0; f < F; f++)
                    for (int j = 0; j < N; j++)
                        chk($sformatf("grad_weight[%0d][%0d]", f, j), bus0.grad_weight[f][j], x_gw[f][j]);
                for (int i = 0; i < B; i++)
                    for (int f = 0; f < F; f++)
                        chk($sformatf("grad_data[%0d][%0d]", i, f), bus0.grad_data[i][f], x_gd[i][f]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic set_in(input bf_t d, input fn_t w, input bn_t g);
        bus0.data     = d;
        bus0.weight   = w;
        bus0.grad_out = g;
    endtask

    // start a pass on u0; lat = cycle (1 = first cycle after accept) with done seen
    task automatic run_pass0(output int lat);
        lat = 0;
        @(posedge clk); #1 bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("clear_grad_bias0", bus0.grad_bias[0], 32'd0);
                chk("clear_grad_weight00", bus0.grad_weight[0][0], 32'd0);
            end
            if (bus0.done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    bf_t va_d = {32'd3, 32'd2, 32'd1};
    fn_t va_w = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    bn_t va_g = {32'd20, 32'd10};
    bf_t vb_d = {32'd3, 32'd2, 32'd1};
    fn_t vb_w = {32'd1, 32'd1, 32'd2, 32'd0, 32'd0, 32'd2};
    bn_t vb_g = {32'hFFFF_FFFE, 32'hFFFF_FFFF};
    bf_t vc_d = {32'd2, 32'd2, 32'd2};
    fn_t vc_w = {32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    bn_t vc_g = {32'd1, 32'h7FFF_FFFF};

    int lat;
    int dones;
    int first_c;
    int second_c;
    logic [31:0] snap0, snap1, snap2;

    initial begin
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        set_in('0, '0, '0);
        bus1.data     = '0;
        bus1.weight   = '0;
        bus1.grad_out = '0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_done", 32'(bus0.done), 32'd0);
        chk("rst_grad_bias1", bus0.grad_bias[1], 32'd0);
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("no_start_after_rst", 32'(bus0.busy), 32'd0);

        // basic pass
        set_in(va_d, va_w, va_g);
        run_pass0(lat);
        chk("latency_a", 32'(lat), GX_ON ? 32'd15 : 32'd9);
        chk("a_grad_bias0", bus0.grad_bias[0], 32'd10);
        chk("a_grad_bias1", bus0.grad_bias[1], 32'd20);
        chk("a_grad_weight00", bus0.grad_weight[0][0], 32'd10);
        chk("a_grad_weight01", bus0.grad_weight[0][1], 32'd20);
        chk("a_grad_weight10", bus0.grad_weight[1][0], 32'd20);
        chk("a_grad_weight11", bus0.grad_weight[1][1], 32'd40);
        chk("a_grad_weight20", bus0.grad_weight[2][0], 32'd30);
        chk("a_grad_weight21", bus0.grad_weight[2][1], 32'd60);
        chk("a_grad_data0", bus0.grad_data[0][0], GX_ON ? 32'd50 : 32'd0);
        chk("a_grad_data1", bus0.grad_data[0][1], GX_ON ? 32'd110 : 32'd0);
        chk("a_grad_data2", bus0.grad_data[0][2], GX_ON ? 32'd170 : 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus0.done), 32'd0);

        // wrap-around
        set_in(vc_d, vc_w, vc_g);
        run_pass0(lat);
        chk("wrap_grad_weight00", bus0.grad_weight[0][0], 32'hFFFF_FFFE);
        chk("wrap_grad_bias0", bus0.grad_bias[0], 32'h7FFF_FFFF);
        chk("wrap_grad_bias1", bus0.grad_bias[1], 32'd1);
        chk("wrap_grad_data0", bus0.grad_data[0][0], GX_ON ? 32'h8000_0000 : 32'd0);

        // signed operands
        set_in(vb_d, vb_w, vb_g);
        run_pass0(lat);
        chk("signed_grad_weight21", bus0.grad_weight[2][1], 32'hFFFF_FFFA);
        chk("signed_grad_bias1", bus0.grad_bias[1], 32'hFFFF_FFFE);

        // start held high, inputs changed mid-pass, back-to-back acceptance
        set_in(va_d, va_w, va_g);
        dones = 0; first_c = 0; second_c = 0;
        snap0 = 32'd0; snap1 = 32'd0; snap2 = 32'd0;
        @(posedge clk); #1 bus0.start = 1'b1;
        for (int c = 0; c <= 2*TERMS + 4; c++) begin
            @(negedge clk);
            if (bus0.done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    first_c = c;
                    snap0 = bus0.grad_bias[0];
                end else begin
                    second_c = c;
                    snap1 = bus0.grad_weight[2][1];
                    snap2 = bus0.grad_data[0][0];
                end
            end
            if (c == 3) set_in(vb_d, vb_w, vb_g);
        end
        #1 bus0.start = 1'b0;
        chk("b2b_done_count", 32'(dones), 32'd2);
        chk("b2b_first_done", 32'(first_c), GX_ON ? 32'd15 : 32'd9);
        chk("b2b_gap", 32'(second_c - first_c), GX_ON ? 32'd16 : 32'd10);
        chk("b2b_pass1_grad_bias0", snap0, 32'd10);
        chk("b2b_pass2_grad_weight21", snap1, 32'hFFFF_FFFA);
        chk("b2b_pass2_grad_data0", snap2, GX_ON ? 32'hFFFF_FFFE : 32'd0);

        // reset during GW
        set_in(va_d, va_w, va_g);
        @(posedge clk); #1 bus0.start = 1'b1;
        @(posedge clk); #1 bus0.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus0.busy), 32'd0);
        chk("midrst_done", 32'(bus0.done), 32'd0);
        chk("midrst_grad_weight00", bus0.grad_weight[0][0], 32'd0);
        chk("midrst_grad_bias0", bus0.grad_bias[0], 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        dones = 0;
        repeat (TERMS + 4) begin
            @(negedge clk);
            if (bus0.done === 1'b1) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);
        run_pass0(lat);
        chk("after_rst_latency", 32'(lat), GX_ON ? 32'd15 : 32'd9);
        chk("after_rst_grad_bias1", bus0.grad_bias[1], 32'd20);

        // batch_size = 2 instance
        bus1.data     = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        bus1.weight   = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        bus1.grad_out = {32'd4, 32'd3, 32'd2, 32'd1};
        @(posedge clk); #1 bus1.start = 1'b1;
        @(posedge clk); #1 bus1.start = 1'b0;
        lat = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (bus1.done === 1'b1) begin
                lat = c;
                break;
            end
        end
        chk("b2_latency", 32'(lat), GX_ON ? 32'd29 : 32'd17);
        chk("b2_grad_bias0", bus1.grad_bias[0], 32'd4);
        chk("b2_grad_bias1", bus1.grad_bias[1], 32'd6);
        chk("b2_grad_weight00", bus1.grad_weight[0][0], 32'd13);
        chk("b2_grad_weight21", bus1.grad_weight[2][1], 32'd30);
        chk("b2_grad_data00", bus1.grad_data[0][0], GX_ON ? 32'd5 : 32'd0);
        chk("b2_grad_data12", bus1.grad_data[1][2], GX_ON ? 32'd39 : 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fc_backward.md
FC_BACKWARD -- requirements
Module: fc_backward

Interface
REQ-001 SHALL have parameter batch_size, default 1, rows of input activation / output gradient.
REQ-002 SHALL have parameter feature_size, default 3, input feature count.
REQ-003 SHALL have parameter bias_size, default 2, output neuron count.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  request one backward pass.
REQ-007 SHALL have port data  input  32 x [batch_size][feature_size]  forward-pass activations.
REQ-008 SHALL have port weight  input  32 x [feature_size][bias_size]  forward-pass weights.
REQ-009 SHALL have port grad_out  input  32 x [batch_size][bias_size]  loss gradient w.r.t. layer output.
REQ-010 SHALL have port grad_data  output  32 x [batch_size][feature_size]  = grad_out x weight^T.
REQ-011 SHALL have port grad_weight  output  32 x [feature_size][bias_size]  = data^T x grad_out.
REQ-012 SHALL have port grad_bias  output  32 x [bias_size]  = column sums of grad_out over batch.
REQ-013 SHALL have port busy  output  1  high while a pass is in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse on completion.

Function
REQ-015 SHALL use states IDLE, GB, GW, GX, DONE; IDLE->GB on start, GB->GW->GX->DONE->IDLE after each phase's last term.
REQ-016 SHALL, on an edge in IDLE with start=1, register data, weight and grad_out internally, clear all gradient outputs to 0, and assert busy.
REQ-017 SHALL ignore start while busy=1 or in DONE; later changes to the input ports SHALL not affect the running pass.
REQ-018 SHALL use one shared 32-bit multiply-accumulate unit, performing exactly one product term per cycle in GB, GW and GX.
REQ-019 SHALL spend batch_size*bias_size cycles in GB, feature_size*bias_size*batch_size in GW, and batch_size*feature_size*bias_size in GX.
REQ-020 SHALL iterate elements row-major (outer index slowest) with the reduction index innermost; write each output element on its last term.
REQ-021 SHALL treat all operands as two's complement; keep the low 32 bits of each product and sum, with wrap-around and no saturation.
REQ-022 SHALL, in GB, use a multiplier operand of 1, i.e. accumulate only.
REQ-023 SHALL hold done=1 and busy=0 for exactly the one DONE cycle, then return to IDLE.
REQ-024 SHALL hold gradient outputs stable from DONE until the next accepted start.
REQ-025 SHALL accept a start asserted in the cycle after DONE (back-to-back passes).

Reset
REQ-026 SHALL, when rst=1, immediately force state IDLE, busy=0, done=0, all gradient outputs and internal registers/counters to 0, including mid-pass.
REQ-027 SHALL not begin a pass on the first edge after rst deasserts unless start=1 at that edge.

Configuration
REQ-028 SHALL compile the GX phase only when macro FC_BACKWARD_GRAD_DATA_EN is defined.
REQ-029 SHALL, without FC_BACKWARD_GRAD_DATA_EN, go GW->DONE, drive grad_data constant 0, and omit the GX cycles from latency.

Verification
REQ-030 Default params, data=[1,2,3], weight=[[1,2],[3,4],[5,6]], grad_out=[10,20], macro on -> grad_bias=[10,20], grad_weight=[[10,20],[20,40],[30,60]], grad_data=[50,110,170], done 15 cycles after start edge.
REQ-031 Same stimulus, macro off -> identical grad_bias/grad_weight, grad_data=[0,0,0], done 9 cycles after start edge.
REQ-032 grad_out=[0x7FFFFFFF,1], data=[2,2,2] -> grad_weight[0][0]=0xFFFFFFFE (wrapped), grad_bias=[0x7FFFFFFF,1].
REQ-033 start held high continuously and inputs changed mid-pass -> exactly one done per pass, results match inputs captured at acceptance, back-to-back pass accepted the cycle after DONE.
REQ-034 rst pulsed during GW -> all outputs 0 and busy=0 asynchronously; no done; a fresh start completes correctly.
REQ-035 batch_size=2, grad_out=[[1,2],[3,4]] -> grad_bias=[4,6]; signed case grad_out=[-1,-2] with data=[1,2,3] -> grad_weight[2][1]=-6.
